// File: rtl/caravel_wb_pkg.sv
// caravel_wb_pkg: shared FSM state encoding, error cause codes and user-space default for the Caravel Wishbone router
package caravel_wb_pkg;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;
  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_TARGET   = 2'd1;
  localparam logic [1:0] CAUSE_UNMAPPED = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'd3;
  localparam logic [3:0] USER_SPACE_DEFAULT = 4'h3;
endpackage

// File: rtl/wb_timeout_counter.sv
// wb_timeout_counter: saturating cycle counter (wb_clk_i, wb_rst_i, clr, en in; expired out when LIMIT reached)
module wb_timeout_counter import caravel_wb_pkg::*; #(
  parameter int LIMIT = 255
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(LIMIT + 1);
  logic [CW-1:0] cnt;
  assign expired = cnt == CW'(LIMIT);
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || clr) cnt <= '0;
    else if (en && !expired) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/caravel_wb_router.sv
// caravel_wb_router: Caravel classic slave (wbs_*) to NUM_TARGETS pipelined targets (m_wb_*), with error/timeout completion and sticky IRQ (err_*)
module caravel_wb_router import caravel_wb_pkg::*; #(
  parameter int          NUM_TARGETS        = 4,
  parameter logic [3:0]  USER_SPACE_ADDRESS = USER_SPACE_DEFAULT,
  parameter int          TARGET_ADDR_W      = 24,
  parameter int          TIMEOUT_CYCLES     = 255,
  parameter logic [31:0] ERROR_DATA         = 32'hFFFF_FFFF
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic                       wbs_cyc_i,
  input  logic                       wbs_stb_i,
  input  logic                       wbs_we_i,
  input  logic [3:0]                 wbs_sel_i,
  input  logic [31:0]                wbs_adr_i,
  input  logic [31:0]                wbs_data_i,
  output logic                       wbs_ack_o,
  output logic [31:0]                wbs_data_o,
  output logic [NUM_TARGETS-1:0]     m_wb_cyc_o,
  output logic [NUM_TARGETS-1:0]     m_wb_stb_o,
  output logic                       m_wb_we_o,
  output logic [3:0]                 m_wb_sel_o,
  output logic [TARGET_ADDR_W-1:0]   m_wb_adr_o,
  output logic [31:0]                m_wb_data_o,
  input  logic [NUM_TARGETS-1:0]     m_wb_ack_i,
  input  logic [NUM_TARGETS-1:0]     m_wb_stall_i,
  input  logic [NUM_TARGETS-1:0]     m_wb_error_i,
  input  logic [32*NUM_TARGETS-1:0]  m_wb_data_i,
  output logic                       err_irq_o,
  input  logic                       err_clear_i,
  output logic [1:0]                 err_cause_o
);
  localparam logic [NUM_TARGETS-1:0] ONE = NUM_TARGETS'(1);
  logic [1:0] state, nxt, cause;
  logic [3:0] tgt;
  logic [NUM_TARGETS-1:0] oh;
  logic busy, req, hit, ack_t, err_t, stall_t, expired, done_ok, done_err;
  logic [31:0] rdata;
  wb_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_tmo (
    .wb_clk_i(wb_clk_i),
    .wb_rst_i(wb_rst_i),
    .clr(state == S_IDLE),
    .en(busy),
    .expired(expired)
  );
  always_comb begin
    oh = ONE << tgt;
    busy = state == S_REQ || state == S_WAIT;
    req = state == S_IDLE && wbs_cyc_i && wbs_stb_i;
    hit = wbs_adr_i[31:28] == USER_SPACE_ADDRESS && {1'b0, wbs_adr_i[27:24]} < 5'(NUM_TARGETS);
    ack_t = |(m_wb_ack_i & oh);
    err_t = |(m_wb_error_i & oh);
    stall_t = |(m_wb_stall_i & oh);
    done_err = (req && !hit) || (busy && wbs_cyc_i && (err_t || (!ack_t && expired)));
    done_ok = busy && wbs_cyc_i && ack_t && !err_t;
    cause = req ? CAUSE_UNMAPPED : err_t ? CAUSE_TARGET : CAUSE_TIMEOUT;
    nxt = state == S_RESP ? S_IDLE :
          req ? (hit ? S_REQ : S_RESP) :
          (!busy || !wbs_cyc_i) ? S_IDLE :
          (done_ok || done_err) ? S_RESP :
          (state == S_REQ && !stall_t) ? S_WAIT : state;
    rdata = '0;
    for (int k = 0; k < NUM_TARGETS; k++)
      if (tgt == 4'(k)) rdata = m_wb_data_i[32*k +: 32];
  end
  assign m_wb_cyc_o = busy ? oh : '0;
  assign m_wb_stb_o = state == S_REQ ? oh : '0;
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= S_IDLE;
      tgt <= '0;
      m_wb_we_o <= 1'b0;
      m_wb_sel_o <= '0;
      m_wb_adr_o <= '0;
      m_wb_data_o <= '0;
      wbs_ack_o <= 1'b0;
      wbs_data_o <= '0;
      err_irq_o <= 1'b0;
      err_cause_o <= CAUSE_NONE;
    end else begin
      state <= nxt;
      wbs_ack_o <= done_ok || done_err;
      err_irq_o <= done_err || (err_irq_o && !err_clear_i);
      if (req && hit) begin
        tgt <= wbs_adr_i[27:24];
        m_wb_we_o <= wbs_we_i;
        m_wb_sel_o <= wbs_sel_i;
        m_wb_adr_o <= wbs_adr_i[TARGET_ADDR_W-1:0];
        m_wb_data_o <= wbs_data_i;
      end
      if (done_err) begin
        wbs_data_o <= ERROR_DATA;
        err_cause_o <= cause;
      end else if (done_ok) wbs_data_o <= rdata;
    end
  end
endmodule

// File: tb/tb_caravel_wb_router.sv
// tb_caravel_wb_router: directed checks of routing, stall, unmapped, timeout, error priority, abort and reset
module tb_caravel_wb_router;
  logic clk = 1'b0, rst = 1'b1;
  logic cyc = 1'b0, stb = 1'b0, we = 1'b0, clr = 1'b0;
  logic [3:0] sel = '0;
  logic [31:0] adr = '0, wdat = '0;
  logic ack, irq;
  logic [31:0] rdat, mdat;
  logic [3:0] mcyc, mstb, mack = '0, mstall = '0, merr = '0;
  logic mwe;
  logic [3:0] msel;
  logic [23:0] madr;
  logic [1:0] cause;
  logic [127:0] tdat = '0;
  int tests = 0, fails = 0, acc = 0;
  caravel_wb_router #(.NUM_TARGETS(4), .TIMEOUT_CYCLES(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_data_i(wdat), .wbs_ack_o(ack), .wbs_data_o(rdat),
    .m_wb_cyc_o(mcyc), .m_wb_stb_o(mstb), .m_wb_we_o(mwe), .m_wb_sel_o(msel),
    .m_wb_adr_o(madr), .m_wb_data_o(mdat),
    .m_wb_ack_i(mack), .m_wb_stall_i(mstall), .m_wb_error_i(merr), .m_wb_data_i(tdat),
    .err_irq_o(irq), .err_clear_i(clr), .err_cause_o(cause)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic up(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
    cyc = 1'b1; stb = 1'b1; adr = a; we = w; wdat = d; sel = s;
  endtask
  task automatic down;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, ".ack"}, 32'(ack), 0);
    chk({tag, ".rdat"}, rdat, 0);
    chk({tag, ".cyc"}, 32'(mcyc), 0);
    chk({tag, ".stb"}, 32'(mstb), 0);
    chk({tag, ".we"}, 32'(mwe), 0);
    chk({tag, ".sel"}, 32'(msel), 0);
    chk({tag, ".adr"}, 32'(madr), 0);
    chk({tag, ".mdat"}, mdat, 0);
    chk({tag, ".irq"}, 32'(irq), 0);
    chk({tag, ".cause"}, 32'(cause), 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    tick; tick;
    chk_zero("reset");
    rst = 1'b0;
    // read target 1, zero-wait ack
    up(32'h3100_0010, 1'b0, 32'h0, 4'hF);
    tick;
    chk("rd.cyc", 32'(mcyc), 32'h2);
    chk("rd.stb", 32'(mstb), 32'h2);
    chk("rd.adr", 32'(madr), 32'h10);
    chk("rd.ack_early", 32'(ack), 0);
    mack = 4'b0010; tdat[63:32] = 32'hDEAD_BEEF;
    tick;
    chk("rd.ack", 32'(ack), 1);
    chk("rd.data", rdat, 32'hDEAD_BEEF);
    chk("rd.irq", 32'(irq), 0);
    chk("rd.cyc_off", 32'(mcyc), 0);
    down; mack = '0;
    tick;
    chk("rd.ack_once", 32'(ack), 0);
    // write target 2 with 3 stalled cycles
    mstall = 4'b0100;
    up(32'h3200_0004, 1'b1, 32'h1234_5678, 4'b0011);
    tick;
    for (int i = 0; i < 4; i++) begin
      chk("wr.stb", 32'(mstb), 32'h4);
      chk("wr.we", 32'(mwe), 1);
      chk("wr.sel", 32'(msel), 32'h3);
      chk("wr.adr", 32'(madr), 32'h4);
      chk("wr.mdat", mdat, 32'h1234_5678);
      if (i == 3) mstall = '0;
      if (mstb[2] && !mstall[2]) acc++;
      tick;
    end
    chk("wr.stb_drop", 32'(mstb), 0);
    chk("wr.cyc_wait", 32'(mcyc), 32'h4);
    chk("wr.accepted", 32'(acc), 1);
    mack = 4'b0100;
    tick;
    chk("wr.ack", 32'(ack), 1);
    down; mack = '0;
    tick;
    chk("wr.ack_once", 32'(ack), 0);
    // unmapped target index 7
    up(32'h3700_0000, 1'b0, 32'h0, 4'hF);
    tick;
    chk("um.ack", 32'(ack), 1);
    chk("um.data", rdat, 32'hFFFF_FFFF);
    chk("um.irq", 32'(irq), 1);
    chk("um.cause", 32'(cause), 2);
    chk("um.cyc", 32'(mcyc), 0);
    down;
    tick;
    chk("um.ack_once", 32'(ack), 0);
    clr = 1'b1;
    tick;
    clr = 1'b0;
    chk("um.clr_irq", 32'(irq), 0);
    chk("um.clr_cause", 32'(cause), 2);
    // timeout on silent target 0
    up(32'h3000_0000, 1'b0, 32'h0, 4'hF);
    tick;
    chk("to.cyc_rise", 32'(mcyc), 32'h1);
    for (int i = 1; i <= 8; i++) begin
      tick;
      chk("to.cyc_hold", 32'(mcyc), 32'h1);
      chk("to.no_ack", 32'(ack), 0);
    end
    tick;
    chk("to.ack", 32'(ack), 1);
    chk("to.cyc_drop", 32'(mcyc), 0);
    chk("to.data", rdat, 32'hFFFF_FFFF);
    chk("to.cause", 32'(cause), 3);
    chk("to.irq", 32'(irq), 1);
    down; clr = 1'b1;
    tick;
    clr = 1'b0;
    chk("to.clr_irq", 32'(irq), 0);
    chk("to.keep_cause", 32'(cause), 3);
    // target 3 ack and error together
    up(32'h3300_0008, 1'b0, 32'h0, 4'hF);
    tick;
    chk("ae.cyc", 32'(mcyc), 32'h8);
    mack = 4'b1000; merr = 4'b1000; tdat[127:96] = 32'h1234_5678;
    tick;
    chk("ae.ack", 32'(ack), 1);
    chk("ae.data", rdat, 32'hFFFF_FFFF);
    chk("ae.cause", 32'(cause), 1);
    chk("ae.irq", 32'(irq), 1);
    down; mack = '0; merr = '0; clr = 1'b1;
    tick;
    clr = 1'b0;
    chk("ae.clr_irq", 32'(irq), 0);
    // upstream abort in WAIT
    up(32'h3100_0000, 1'b0, 32'h0, 4'hF);
    tick; tick;
    chk("ab.wait_cyc", 32'(mcyc), 32'h2);
    chk("ab.wait_stb", 32'(mstb), 0);
    down;
    tick;
    chk("ab.cyc_off", 32'(mcyc), 0);
    chk("ab.no_ack", 32'(ack), 0);
    tick;
    chk("ab.no_ack2", 32'(ack), 0);
    chk("ab.no_irq", 32'(irq), 0);
    up(32'h3100_0020, 1'b0, 32'h0, 4'hF);
    tick;
    chk("ab.next_cyc", 32'(mcyc), 32'h2);
    mack = 4'b0010; tdat[63:32] = 32'hCAFE_F00D;
    tick;
    chk("ab.next_ack", 32'(ack), 1);
    chk("ab.next_data", rdat, 32'hCAFE_F00D);
    down; mack = '0;
    tick;
    // reset while waiting on target 2
    up(32'h3200_0004, 1'b1, 32'hAAAA_5555, 4'hF);
    tick; tick;
    chk("rs.wait_cyc", 32'(mcyc), 32'h4);
    rst = 1'b1; down;
    tick;
    chk_zero("rs");
    rst = 1'b0;
    up(32'h3200_0000, 1'b0, 32'h0, 4'hF);
    tick;
    chk("rs.next_cyc", 32'(mcyc), 32'h4);
    mack = 4'b0100; tdat[95:64] = 32'h0BAD_F00D;
    tick;
    chk("rs.next_ack", 32'(ack), 1);
    chk("rs.next_data", rdat, 32'h0BAD_F00D);
    down; mack = '0;
    tick;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
